shift_sequencer: RTL and testbench



---
 rtl/shift_sequencer_pkg.sv | 15 +
 rtl/shift_sequencer_if.sv | 29 ++
 rtl/shift_reg_core.sv | 51 +++++
 rtl/shift_sequencer.sv | 107 ++++++++++
 tb/tb_shift_sequencer.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/shift_sequencer_pkg.sv
// Shared definitions for the shift sequencer: FSM state encoding and
// shift-direction constants.
package shift_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_e;

    localparam logic DIR_MSB_FIRST = 1'b0;
    localparam logic DIR_LSB_FIRST = 1'b1;

endpackage

// File: rtl/shift_sequencer_if.sv
// Host-side handshake and data bus of the shift sequencer.
// The master modport is the host; the slave modport is the sequencer.
interface shift_sequencer_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
);
    logic             start;
    logic             dir;
    logic [WIDTH-1:0] load_data;
    logic             serial_in;
    logic             abort;
    logic             ready;
    logic             busy;
    logic             done;
    logic             shift_en;
    logic             serial_out;
    logic [WIDTH-1:0] par_out;
    logic [CNT_W-1:0] bit_count;

    modport master (
        output start, dir, load_data, serial_in, abort,
        input  ready, busy, done, shift_en, serial_out, par_out, bit_count
    );

    modport slave (
        input  start, dir, load_data, serial_in, abort,
        output ready, busy, done, shift_en, serial_out, par_out, bit_count
    );
endinterface

// File: rtl/shift_reg_core.sv
// WIDTH-bit bidirectional shift register with parallel load; load wins over
// shift, and an idle register holds its value.
module shift_reg_core
    import shift_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             shift_en,
    input  logic             dir,
    input  logic             serial_in,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;
    logic [WIDTH-1:0] shifted;

    // A one-bit register has no neighbour to shift from, so it just captures serial_in.
    if (WIDTH == 1) begin : g_w1
        assign shifted = serial_in;
    end else begin : g_wn
        assign shifted = (dir == DIR_LSB_FIRST) ? {serial_in, q_q[WIDTH-1:1]}
                                                : {q_q[WIDTH-2:0], serial_in};
    end

    // NOTE: every variable written here gets a value on every path, so no latch is inferred.
    always_comb begin
        q_d = q_q;
        if (load) begin
            q_d = load_data;
        end else if (shift_en) begin
            q_d = shifted;
        end
    end

    // NOTE: non-blocking assignment so all flops update together from pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/shift_sequencer.sv
// Sequences one serial transfer: parallel load, WIDTH shifts with serial capture,
// one-cycle done pulse; abortable from LOAD or SHIFT.
module shift_sequencer
    import shift_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic              clock,
    input  logic              reset,
    shift_sequencer_if.slave  bus
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_e           state_q, state_d;
    logic             dir_q, dir_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ready_q, ready_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             shift_en_q, shift_en_d;
    logic             load;
    logic             shift;
    logic [WIDTH-1:0] reg_q;

    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        cnt_d   = cnt_q;
        load    = 1'b0;
        shift   = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = LOAD;
                    dir_d   = bus.dir;
                    cnt_d   = '0;
                    load    = 1'b1;
                end
            end
            LOAD:    state_d = bus.abort ? IDLE : SHIFT;
            SHIFT: begin
                // Abort freezes the register and counter on this edge.
                if (bus.abort) begin
                    state_d = IDLE;
                end else begin
                    shift = 1'b1;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LAST_CNT) begin
                        state_d = DONE;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Outputs are registered from the next state so they align with it.
        ready_d    = (state_d == IDLE);
        busy_d     = (state_d == LOAD) || (state_d == SHIFT);
        done_d     = (state_d == DONE);
        shift_en_d = (state_d == SHIFT);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            dir_q      <= DIR_MSB_FIRST;
            cnt_q      <= '0;
            ready_q    <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            shift_en_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            dir_q      <= dir_d;
            cnt_q      <= cnt_d;
            ready_q    <= ready_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            shift_en_q <= shift_en_d;
        end
    end

    shift_reg_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .clock     (clock),
        .reset     (reset),
        .load      (load),
        .load_data (bus.load_data),
        .shift_en  (shift),
        .dir       (dir_q),
        .serial_in (bus.serial_in),
        .q         (reg_q)
    );

    assign bus.ready      = ready_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.shift_en   = shift_en_q;
    assign bus.serial_out = (dir_q == DIR_LSB_FIRST) ? reg_q[0] : reg_q[WIDTH-1];
    assign bus.par_out    = reg_q;
    assign bus.bit_count  = cnt_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed and randomized bench for shift_sequencer (WIDTH=8 and WIDTH=1 instances)
// against a bit-stream reference model.
module tb_shift_sequencer;

    logic clock;
    logic reset;
    logic loop_en;
    logic si_drv;
    int   n_total;
    int   n_pass;

    shift_sequencer_if #(.WIDTH(8)) bus  ();
    shift_sequencer_if #(.WIDTH(1)) bus1 ();

    assign bus.serial_in = loop_en ? bus.serial_out : si_drv;

    shift_sequencer #(.WIDTH(8)) dut8 (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    shift_sequencer #(.WIDTH(1)) dut1 (
        .clock (clock),
        .reset (reset),
        .bus   (bus1)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Bit i of the transmitted stream: MSB-first walks down from bit 7, LSB-first up from bit 0.
    function automatic logic exp_bit(input logic [7:0] w, input logic d, input int i);
        return d ? w[i] : w[7 - i];
    endfunction

    // Register contents after n shifts, given the word and the received bit stream sin[0..n-1].
    function automatic logic [7:0] exp_word(input logic [7:0] w, input logic d,
                                            input logic [7:0] sin, input int n);
        logic [15:0] acc;
        if (!d) begin
            acc = {8'h00, w} << n;
            for (int i = 0; i < n; i++) acc = acc | (16'(sin[i]) << (n - 1 - i));
        end else begin
            acc = {8'h00, w} >> n;
            for (int i = 0; i < n; i++) acc = acc | (16'(sin[i]) << (8 - n + i));
        end
        return acc[7:0];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Full 8-bit transfer; checks LOAD, every SHIFT cycle, DONE and the return to IDLE.
    task automatic transfer(input logic [7:0] w, input logic d, input logic loop, input logic rnd);
        logic [7:0] sin;
        int         en_cycles;
        sin       = '0;
        en_cycles = 0;
        loop_en   = loop;
        bus.load_data = w;
        bus.dir       = d;
        bus.start     = 1'b1;
        step();
        bus.start = 1'b0;
        chk("load_busy", 32'(bus.busy), 32'd1);
        chk("load_ready", 32'(bus.ready), 32'd0);
        chk("load_sout", 32'(bus.serial_out), 32'(exp_bit(w, d, 0)));
        step();
        for (int i = 0; i < 8; i++) begin
            si_drv = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
            sin[i] = loop ? exp_bit(w, d, i) : si_drv;
            if (bus.shift_en === 1'b1) en_cycles++;
            chk("shift_sout", 32'(bus.serial_out), 32'(exp_bit(w, d, i)));
            chk("shift_cnt", 32'(bus.bit_count), 32'(i));
            step();
        end
        chk("shift_en_cycles", 32'(en_cycles), 32'd8);
        chk("done_pulse", 32'(bus.done), 32'd1);
        chk("done_shift_en", 32'(bus.shift_en), 32'd0);
        chk("done_cnt", 32'(bus.bit_count), 32'd8);
        chk("done_par", 32'(bus.par_out), 32'(exp_word(w, d, sin, 8)));
        step();
        chk("after_ready", 32'(bus.ready), 32'd1);
        chk("after_done", 32'(bus.done), 32'd0);
        chk("after_par_hold", 32'(bus.par_out), 32'(exp_word(w, d, sin, 8)));
        loop_en = 1'b0;
    endtask

    initial begin
        logic [7:0] sin;
        n_total = 0;
        n_pass  = 0;
        loop_en = 1'b0;
        si_drv  = 1'b0;
        bus.start = 1'b0; bus.dir = 1'b0; bus.load_data = '0; bus.abort = 1'b0;
        bus1.start = 1'b0; bus1.dir = 1'b0; bus1.load_data = '0; bus1.abort = 1'b0;
        bus1.serial_in = 1'b0;
        reset = 1'b1;
        step();
        step();
        chk("rst_ready", 32'(bus.ready), 32'd1);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_shift_en", 32'(bus.shift_en), 32'd0);
        chk("rst_sout", 32'(bus.serial_out), 32'd0);
        chk("rst_par", 32'(bus.par_out), 32'd0);
        chk("rst_cnt", 32'(bus.bit_count), 32'd0);
        reset = 1'b0;
        step();

        // Asynchronous reset mid-SHIFT at bit_count=3.
        bus.load_data = 8'hA5; bus.dir = 1'b0; bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        repeat (4) step();
        chk("mid_cnt", 32'(bus.bit_count), 32'd3);
        #2 reset = 1'b1;
        #1;
        chk("async_ready", 32'(bus.ready), 32'd1);
        chk("async_busy", 32'(bus.busy), 32'd0);
        chk("async_par", 32'(bus.par_out), 32'd0);
        chk("async_cnt", 32'(bus.bit_count), 32'd0);
        chk("async_shift_en", 32'(bus.shift_en), 32'd0);
        #2 reset = 1'b0;
        step();

        transfer(8'hC8, 1'b0, 1'b1, 1'b0);
        transfer(8'hC8, 1'b1, 1'b1, 1'b0);
        transfer(8'hFF, 1'b0, 1'b0, 1'b0);

        // Second start during SHIFT is ignored; abort at bit_count=5 freezes state.
        sin = '0;
        bus.load_data = 8'h3C; bus.dir = 1'b1; bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        step();
        for (int i = 0; i < 5; i++) begin
            bus.start = (i == 2);
            si_drv = 1'($urandom_range(0, 1));
            sin[i] = si_drv;
            step();
        end
        bus.start = 1'b0;
        chk("abort_pre_cnt", 32'(bus.bit_count), 32'd5);
        chk("abort_pre_busy", 32'(bus.busy), 32'd1);
        bus.abort = 1'b1;
        si_drv = ~si_drv;
        step();
        bus.abort = 1'b0;
        chk("abort_ready", 32'(bus.ready), 32'd1);
        chk("abort_busy", 32'(bus.busy), 32'd0);
        chk("abort_done", 32'(bus.done), 32'd0);
        chk("abort_cnt", 32'(bus.bit_count), 32'd5);
        chk("abort_par", 32'(bus.par_out), 32'(exp_word(8'h3C, 1'b1, sin, 5)));
        step();
        chk("abort_no_done", 32'(bus.done), 32'd0);
        chk("abort_par_hold", 32'(bus.par_out), 32'(exp_word(8'h3C, 1'b1, sin, 5)));
        transfer(8'h5A, 1'b0, 1'b0, 1'b1);

        // start and abort together in IDLE: start wins; then abort from LOAD.
        bus.load_data = 8'h96; bus.dir = 1'b0; bus.start = 1'b1; bus.abort = 1'b1;
        step();
        bus.start = 1'b0;
        chk("start_wins_busy", 32'(bus.busy), 32'd1);
        step();
        bus.abort = 1'b0;
        chk("load_abort_ready", 32'(bus.ready), 32'd1);
        chk("load_abort_par", 32'(bus.par_out), 32'h96);
        chk("load_abort_cnt", 32'(bus.bit_count), 32'd0);

        repeat (4) transfer(8'($urandom), 1'($urandom_range(0, 1)), 1'b0, 1'b1);

        // WIDTH=1 instance: one SHIFT cycle, done at k+3.
        bus1.load_data = 1'b1; bus1.serial_in = 1'b0; bus1.start = 1'b1;
        step();
        bus1.start = 1'b0;
        chk("w1_load_busy", 32'(bus1.busy), 32'd1);
        chk("w1_load_sout", 32'(bus1.serial_out), 32'd1);
        step();
        chk("w1_shift_en", 32'(bus1.shift_en), 32'd1);
        chk("w1_shift_sout", 32'(bus1.serial_out), 32'd1);
        step();
        chk("w1_done", 32'(bus1.done), 32'd1);
        chk("w1_par", 32'(bus1.par_out), 32'd0);
        chk("w1_cnt", 32'(bus1.bit_count), 32'd1);
        step();
        chk("w1_ready", 32'(bus1.ready), 32'd1);
        chk("w1_done_clear", 32'(bus1.done), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
